i8088_bus_master: RTL
=====================

// Module: i8088_bus_master
// PURPOSE
//  Synthesizable 8088-style minimum-mode bus initiator: turns a simple request/response
//  port into T1-T4 multiplexed bus cycles (ALE, RD, WR, IOM, DTR, DEN, AD[7:0], A[19:8]).
//  Plugs into the existing 8282 latch / 8286 transceiver / IOM responder fabric in place
//  of the processor model; used by DMA-style engines and bench traffic generators.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max consecutive TW states before abort (only with BUS_TIMEOUT_EN)
// PORTS
//  CLK        in     1   clock, all state changes on posedge
//  RESET      in     1   synchronous, active-high reset
//  req_valid  in     1   request present
//  req_ready  out    1   request accepted on posedge when req_valid & req_ready
//  req_addr   in     20  byte address (IO cycles use [15:0])
//  req_wdata  in     8   write data
//  req_write  in     1   1=write, 0=read
//  req_io     in     1   1=IO space, 0=memory
//  rsp_valid  out    1   one-cycle completion pulse (reads and writes)
//  rsp_rdata  out    8   read data, valid with rsp_valid on reads
//  rsp_err    out    1   timeout abort flag, valid with rsp_valid
//  READY      in     1   wait-state control from responders
//  AD         inout  8   multiplexed address/data
//  A          out    12  address [19:8]
//  ALE IOM RD WR DTR DEN  out 1 each, same meaning/polarity as 8088 pins
// BEHAVIOUR
//  - All outputs registered. Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    AD=Z, A=0, ALE=0, IOM=0, RD=1, WR=1, DTR=1, DEN=1; FSM=IDLE.
//  - FSM: IDLE -> T1 -> T2 -> T3 -> {TW}* -> T4 -> IDLE, or T4 -> T1 if a request is accepted in T4.
//  - req_ready=1 only in IDLE and T4; request fields captured at the accepting edge.
//  - T1: ALE=1; AD drives addr[7:0]; A drives addr[19:8]; IO cycle forces A[19:16]=0;
//    IOM=req_io; DTR=req_write; DEN=1; RD=WR=1.
//  - T2,T3,TW: ALE=0; A held; DEN=0. Read: AD=Z, RD=0. Write: AD=wdata, WR=0.
//  - T3/TW exit: READY sampled at posedge ending the state; 1 -> T4, 0 -> TW.
//    Read data captured from AD on that same edge.
//  - T4: RD=WR=1; rsp_valid=1 for one cycle; rsp_rdata=captured data (reads), unchanged (writes).
//    Write: AD still driven, DEN=0. Read: AD=Z, DEN=1.
//    IOM/DTR held through T4; in IDLE they return to 0/1.
//  - Min latency: accept edge -> rsp_valid 4 cycles later (T1,T2,T3,T4). Each TW adds 1.
//    Back-to-back throughput: 4 cycles/transfer.
//  - DEN is never 0 while DTR changes; DEN=1 and RD=1 in T1 (no transceiver contention).
//  - RESET mid-cycle: next edge forces IDLE and all reset values. In-flight request dropped,
//    no rsp_valid.
//  - Accept and RESET on the same edge: RESET wins; request not taken.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//    - 8-bit TW counter; when TIMEOUT_CYCLES consecutive TW states elapse with READY=0,
//      go to T4 regardless of READY.
//    - That T4 gives rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF.
//    - Counter clears in T1.
//  BUS_TIMEOUT_EN undefined:
//    - TW persists indefinitely while READY=0.
//    - rsp_err tied 0; no counter logic.
// TESTING
//  1 Mem read 0x80010, responder holds 0xA5, READY=1:
//    ALE only in T1; AD=0x10, A=0x800, IOM=0; rsp_valid 4 cycles after accept; rsp_rdata=0xA5.
//  2 IO write 0x1C05 data 0x3C:
//    A[19:16]=0, IOM=1, WR low T2-T3, AD=0x3C T2-T4; responder stores 0x3C; rsp_err=0.
//  3 Mem read, READY=0 for 3 samples:
//    exactly 3 TW states; RD low 5 cycles; rsp_valid 7 cycles after accept.
//  4 Back-to-back: write 0x00100=0x11 then read 0x00100, req_valid held:
//    second T1 immediately follows first T4; read returns 0x11.
//  5 RESET asserted during T3 of a write:
//    next cycle all outputs at reset values; no rsp_valid; responder memory unchanged.
//  6 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, READY stuck 0:
//    4 TW then T4; rsp_err=1, rsp_rdata=0xFF. Without the macro: bus stays in TW.

Source files
------------

// File: rtl/i8088_bus_master_if.sv
// Request/response port between a traffic source and i8088_bus_master.
// The source side uses modport master; the bus engine uses modport slave.
interface i8088_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_write;
    logic        req_io;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_write, req_io,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_write, req_io,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/i8088_bus_master.sv
// 8088 minimum-mode bus initiator: request/response port to T1-T4 multiplexed bus cycles.
// Optional wait-state abort enabled by defining BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module i8088_bus_master (
    input  logic               CLK,
    input  logic               RESET,
    i8088_bus_master_if.slave  req,
    input  logic               READY,
    inout  wire  [7:0]         AD,
    output logic [11:0]        A,
    output logic               ALE,
    output logic               IOM,
    output logic               RD,
    output logic               WR,
    output logic               DTR,
    output logic               DEN
);
`ifdef BUS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned TW_CNT_W = 8;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    logic [2:0]  state, state_n;
    logic        write_q, write_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        ad_oe, ad_oe_n;
    logic [7:0]  ad_out, ad_out_n;
    logic [11:0] a_n;
    logic        ale_n, iom_n, rd_n, wr_n, dtr_n, den_n;
    logic        req_ready_n, rsp_valid_n, rsp_err_n;
    logic [7:0]  rsp_rdata_n;
    logic        accept;
    logic        tw_expired;

    assign accept = req.req_valid & req.req_ready;
    assign AD     = ad_oe ? ad_out : 8'hzz;

`ifdef BUS_TIMEOUT_EN
    logic [TW_CNT_W-1:0] tw_cnt, tw_cnt_n;

    assign tw_expired = (state == S_TW) && (tw_cnt == TW_CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts completed wait states of the current cycle; restarts in T1.
    always_comb begin
        tw_cnt_n = tw_cnt;
        if (state == S_T1) begin
            tw_cnt_n = '0;
        end else if (state == S_TW && !READY) begin
            tw_cnt_n = tw_cnt + TW_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tw_cnt <= '0;
        end else begin
            tw_cnt <= tw_cnt_n;
        end
    end
`else
    assign tw_expired = 1'b0;
`endif

    // Next state and next registered pin/port values.
    always_comb begin
        state_n     = state;
        write_n     = write_q;
        wdata_n     = wdata_q;
        ad_oe_n     = ad_oe;
        ad_out_n    = ad_out;
        a_n         = A;
        ale_n       = 1'b0;
        iom_n       = IOM;
        rd_n        = RD;
        wr_n        = WR;
        dtr_n       = DTR;
        den_n       = DEN;
        req_ready_n = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_err_n   = req.rsp_err;
        rsp_rdata_n = req.rsp_rdata;

        case (state)
            S_IDLE, S_T4: begin
                if (accept) begin
                    state_n  = S_T1;
                    write_n  = req.req_write;
                    wdata_n  = req.req_wdata;
                    ale_n    = 1'b1;
                    ad_oe_n  = 1'b1;
                    ad_out_n = req.req_addr[7:0];
                    a_n      = req.req_io ? {4'h0, req.req_addr[15:8]} : req.req_addr[19:8];
                    iom_n    = req.req_io;
                    dtr_n    = req.req_write;
                    den_n    = 1'b1;
                    rd_n     = 1'b1;
                    wr_n     = 1'b1;
                end else begin
                    state_n     = S_IDLE;
                    req_ready_n = 1'b1;
                    ad_oe_n     = 1'b0;
                    iom_n       = 1'b0;
                    dtr_n       = 1'b1;
                    den_n       = 1'b1;
                    rd_n        = 1'b1;
                    wr_n        = 1'b1;
                end
            end
            S_T1: begin
                state_n = S_T2;
                den_n   = 1'b0;
                if (write_q) begin
                    ad_oe_n  = 1'b1;
                    ad_out_n = wdata_q;
                    wr_n     = 1'b0;
                end else begin
                    ad_oe_n = 1'b0;
                    rd_n    = 1'b0;
                end
            end
            S_T2: begin
                state_n = S_T3;
            end
            S_T3, S_TW: begin
                if (READY || tw_expired) begin
                    state_n     = S_T4;
                    rd_n        = 1'b1;
                    wr_n        = 1'b1;
                    rsp_valid_n = 1'b1;
                    req_ready_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    if (!write_q) begin
                        rsp_rdata_n = AD;
                        ad_oe_n     = 1'b0;
                        den_n       = 1'b1;
                    end
                    // Aborted cycle: flag the error and return all-ones data.
                    if (!READY) begin
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = 8'hFF;
                    end
                end else begin
                    state_n = S_TW;
                end
            end
            default: begin
                state_n     = S_IDLE;
                req_ready_n = 1'b1;
                ad_oe_n     = 1'b0;
                iom_n       = 1'b0;
                dtr_n       = 1'b1;
                den_n       = 1'b1;
                rd_n        = 1'b1;
                wr_n        = 1'b1;
            end
        endcase
    end

    // State and all outputs registered; synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            write_q       <= 1'b0;
            wdata_q       <= 8'h00;
            ad_oe         <= 1'b0;
            ad_out        <= 8'h00;
            A             <= 12'h000;
            ALE           <= 1'b0;
            IOM           <= 1'b0;
            RD            <= 1'b1;
            WR            <= 1'b1;
            DTR           <= 1'b1;
            DEN           <= 1'b1;
            req.req_ready <= 1'b1;
            req.rsp_valid <= 1'b0;
            req.rsp_err   <= 1'b0;
            req.rsp_rdata <= 8'h00;
        end else begin
            state         <= state_n;
            write_q       <= write_n;
            wdata_q       <= wdata_n;
            ad_oe         <= ad_oe_n;
            ad_out        <= ad_out_n;
            A             <= a_n;
            ALE           <= ale_n;
            IOM           <= iom_n;
            RD            <= rd_n;
            WR            <= wr_n;
            DTR           <= dtr_n;
            DEN           <= den_n;
            req.req_ready <= req_ready_n;
            req.rsp_valid <= rsp_valid_n;
            req.rsp_err   <= rsp_err_n;
            req.rsp_rdata <= rsp_rdata_n;
        end
    end
endmodule
